pow_arb: RTL and testbench

POW_ARB -- requirements
Module: pow_arb

---
 rtl/pow_arb_pkg.sv | 7 +
 rtl/pow_arb_fifo.sv | 44 ++++
 rtl/pow_arb.sv | 147 ++++++++++++++
 tb/tb_pow_arb.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pow_arb_pkg.sv
// Shared defaults and requester IDs for the two-requester power-engine arbiter.
package pow_arb_pkg;
   localparam int   FIFO_DEPTH_DEF = 4;
   localparam int   DATA_W_DEF     = 32;
   localparam logic TID_REQ0       = 1'b0;
   localparam logic TID_REQ1       = 1'b1;
endpackage

// File: rtl/pow_arb_fifo.sv
// Synchronous first-word-fall-through return buffer; writes become visible the cycle after the push.
module pow_arb_fifo #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] head,
   output logic              full,
   output logic              empty
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] PTR_ONE = 1;

   logic [DATA_W-1:0] mem [DEPTH];
   logic [AW:0]       wr_ptr;
   logic [AW:0]       rd_ptr;
   logic              pop_en;
   logic              push_en;

   assign empty   = (wr_ptr == rd_ptr);
   assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
   assign pop_en  = pop & ~empty;
   // A pop frees the head slot in the same cycle, so a full buffer may still take a push.
   assign push_en = push & (~full | pop_en);
   assign head    = mem[rd_ptr[AW-1:0]];

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
      end else begin
         if (push_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (pop_en)  rd_ptr <= rd_ptr + PTR_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (push_en) mem[wr_ptr[AW-1:0]] <= push_data;
   end
endmodule

// File: rtl/pow_arb.sv
// Round-robin arbiter sharing one power engine between two requesters, with
// per-requester credit counting and result return buffers.
module pow_arb
   import pow_arb_pkg::*;
#(
   parameter int FIFO_DEPTH = FIFO_DEPTH_DEF,
   parameter int DATA_W     = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              s0_tvalid,
   output logic              s0_tready,
   input  logic [DATA_W-1:0] s0_tdata,
   input  logic              s1_tvalid,
   output logic              s1_tready,
   input  logic [DATA_W-1:0] s1_tdata,
   output logic              e_tvalid,
   input  logic              e_tready,
   output logic [DATA_W-1:0] e_tdata,
   output logic              e_tid,
   input  logic              r_tvalid,
   output logic              r_tready,
   input  logic [DATA_W-1:0] r_tdata,
   input  logic              r_tid,
   output logic              m0_tvalid,
   input  logic              m0_tready,
   output logic [DATA_W-1:0] m0_tdata,
   output logic              m1_tvalid,
   input  logic              m1_tready,
   output logic [DATA_W-1:0] m1_tdata,
   output logic              err_ovf
);
   localparam int CW = $clog2(FIFO_DEPTH) + 1;
   localparam logic [CW-1:0] CNT_MAX = CW'(FIFO_DEPTH);
   localparam logic [CW-1:0] CNT_ONE = 1;

   logic [CW-1:0] cnt_0;
   logic [CW-1:0] cnt_1;
   logic          last_gnt;
   logic          lock_q;
   logic          lock_id_q;
   logic          elig_0;
   logic          elig_1;
   logic          gnt_any;
   logic          gnt_id;
   logic          issue;
   logic          issue_0;
   logic          issue_1;
   logic          push_0;
   logic          push_1;
   logic          pop_0;
   logic          pop_1;
   logic          full_0;
   logic          full_1;
   logic          empty_0;
   logic          empty_1;

   assign elig_0 = s0_tvalid & (cnt_0 < CNT_MAX);
   assign elig_1 = s1_tvalid & (cnt_1 < CNT_MAX);

   // A stalled grant is pinned so a credit freed mid-stall cannot swap the offered operand.
   always_comb begin
      gnt_any = 1'b0;
      gnt_id  = TID_REQ0;
      if (!rst) begin
         if (lock_q && ((lock_id_q == TID_REQ1) ? elig_1 : elig_0)) begin
            gnt_any = 1'b1;
            gnt_id  = lock_id_q;
         end else if (elig_0 && elig_1) begin
            gnt_any = 1'b1;
            gnt_id  = ~last_gnt;
         end else if (elig_0) begin
            gnt_any = 1'b1;
            gnt_id  = TID_REQ0;
         end else if (elig_1) begin
            gnt_any = 1'b1;
            gnt_id  = TID_REQ1;
         end
      end
   end

   assign e_tvalid  = gnt_any;
   assign e_tid     = gnt_id;
   assign e_tdata   = (gnt_id == TID_REQ1) ? s1_tdata : s0_tdata;
   assign issue     = gnt_any & e_tready;
   assign issue_0   = issue & (gnt_id == TID_REQ0);
   assign issue_1   = issue & (gnt_id == TID_REQ1);
   assign s0_tready = issue_0;
   assign s1_tready = issue_1;
   assign r_tready  = 1'b1;

   assign push_0    = r_tvalid & (r_tid == TID_REQ0);
   assign push_1    = r_tvalid & (r_tid == TID_REQ1);
   assign m0_tvalid = ~empty_0 & ~rst;
   assign m1_tvalid = ~empty_1 & ~rst;
   assign pop_0     = m0_tvalid & m0_tready;
   assign pop_1     = m1_tvalid & m1_tready;

   always_ff @(posedge clk) begin
      if (rst) begin
         last_gnt  <= TID_REQ1;
         lock_q    <= 1'b0;
         lock_id_q <= TID_REQ0;
         err_ovf   <= 1'b0;
      end else begin
         if (issue) last_gnt <= gnt_id;
         lock_q    <= gnt_any & ~e_tready;
         lock_id_q <= gnt_id;
         if ((push_0 & full_0 & ~pop_0) | (push_1 & full_1 & ~pop_1)) err_ovf <= 1'b1;
      end
   end

   // Credits: issued-but-unreturned plus buffered; floor at zero guards against stray results.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_0 <= '0;
         cnt_1 <= '0;
      end else begin
         if (issue_0 && !pop_0)                      cnt_0 <= cnt_0 + CNT_ONE;
         else if (pop_0 && !issue_0 && cnt_0 != '0)  cnt_0 <= cnt_0 - CNT_ONE;
         if (issue_1 && !pop_1)                      cnt_1 <= cnt_1 + CNT_ONE;
         else if (pop_1 && !issue_1 && cnt_1 != '0)  cnt_1 <= cnt_1 - CNT_ONE;
      end
   end

   pow_arb_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo_0 (
      .clk       (clk),
      .rst       (rst),
      .push      (push_0),
      .push_data (r_tdata),
      .pop       (pop_0),
      .head      (m0_tdata),
      .full      (full_0),
      .empty     (empty_0)
   );

   pow_arb_fifo #(.DEPTH(FIFO_DEPTH), .DATA_W(DATA_W)) u_fifo_1 (
      .clk       (clk),
      .rst       (rst),
      .push      (push_1),
      .push_data (r_tdata),
      .pop       (pop_1),
      .head      (m1_tdata),
      .full      (full_1),
      .empty     (empty_1)
   );
endmodule

// File: tb/tb_pow_arb.sv
// Directed bench for pow_arb with a 5-stage x^5 engine model on the issue/result streams.
module tb_pow_arb;
   localparam int DW = 32;

   logic          clk = 1'b0;
   logic          rst;
   logic          s0_tvalid, s0_tready, s1_tvalid, s1_tready;
   logic [DW-1:0] s0_tdata, s1_tdata;
   logic          e_tvalid, e_tready, e_tid;
   logic [DW-1:0] e_tdata;
   logic          r_tvalid, r_tready, r_tid;
   logic [DW-1:0] r_tdata;
   logic          m0_tvalid, m0_tready, m1_tvalid, m1_tready;
   logic [DW-1:0] m0_tdata, m1_tdata;
   logic          err_ovf;

   logic          eng_v, eng_tid, inj_v, inj_tid;
   logic [DW-1:0] eng_data, inj_data;
   logic          pv [5];
   logic          pt [5];
   logic [DW-1:0] pd [5];
   logic          hs, hs_tid, eng_clr;
   logic [DW-1:0] hs_data;

   logic [DW-1:0] exp_q [$];
   int            n_chk = 0;
   int            n_err = 0;

   assign r_tvalid = eng_v | inj_v;
   assign r_tid    = inj_v ? inj_tid : eng_tid;
   assign r_tdata  = inj_v ? inj_data : eng_data;

   always #5 clk = ~clk;

   pow_arb dut (
      .clk(clk), .rst(rst),
      .s0_tvalid(s0_tvalid), .s0_tready(s0_tready), .s0_tdata(s0_tdata),
      .s1_tvalid(s1_tvalid), .s1_tready(s1_tready), .s1_tdata(s1_tdata),
      .e_tvalid(e_tvalid), .e_tready(e_tready), .e_tdata(e_tdata), .e_tid(e_tid),
      .r_tvalid(r_tvalid), .r_tready(r_tready), .r_tdata(r_tdata), .r_tid(r_tid),
      .m0_tvalid(m0_tvalid), .m0_tready(m0_tready), .m0_tdata(m0_tdata),
      .m1_tvalid(m1_tvalid), .m1_tready(m1_tready), .m1_tdata(m1_tdata),
      .err_ovf(err_ovf)
   );

   function automatic logic [DW-1:0] pow5(input logic [DW-1:0] x);
      return x * x * x * x * x;
   endfunction

   task automatic chk_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   task automatic send0(input logic [DW-1:0] v);
      s0_tvalid = 1'b1;
      s0_tdata  = v;
      tick();
   endtask

   // Pops m0 for max_cyc cycles (caller holds m0_tready=1), comparing against exp_q.
   task automatic collect_m0(input string tag, input int max_cyc, input bit bypass_chk);
      int n_exp = exp_q.size();
      int got   = 0;
      bit m1_seen = 1'b0;
      bit r_seen  = 1'b0;
      for (int c = 0; c < max_cyc; c++) begin
         @(negedge clk);
         if (m1_tvalid) m1_seen = 1'b1;
         if (bypass_chk && r_tvalid && !r_seen) begin
            r_seen = 1'b1;
            chk_val({tag, "_no_bypass"}, m0_tvalid, 1'b0);
         end
         if (m0_tvalid && m0_tready) begin
            if (exp_q.size() > 0) chk_val({tag, "_data"}, m0_tdata, exp_q.pop_front());
            got++;
         end
         tick();
      end
      chk_val({tag, "_count"}, got, n_exp);
      chk_val({tag, "_m1_quiet"}, m1_seen, 1'b0);
   endtask

   // Engine model: handshake sampled mid-cycle, result appears on r_* five edges later.
   initial begin
      for (int i = 0; i < 5; i++) begin
         pv[i] = 1'b0; pt[i] = 1'b0; pd[i] = '0;
      end
      eng_v = 1'b0; eng_tid = 1'b0; eng_data = '0;
      forever begin
         @(negedge clk);
         hs      = e_tvalid & e_tready & ~rst;
         hs_tid  = e_tid;
         hs_data = pow5(e_tdata);
         eng_clr = rst;
         @(posedge clk);
         #1;
         for (int i = 4; i > 0; i--) begin
            pv[i] = pv[i-1]; pt[i] = pt[i-1]; pd[i] = pd[i-1];
         end
         pv[0] = hs; pt[0] = hs_tid; pd[0] = hs_data;
         if (eng_clr) for (int i = 0; i < 5; i++) pv[i] = 1'b0;
         eng_v = pv[4]; eng_tid = pt[4]; eng_data = pd[4];
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n0, n1, n1_after;
      bit any_v;

      rst = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 7; s1_tvalid = 1'b1; s1_tdata = 8;
      e_tready = 1'b1; m0_tready = 1'b1; m1_tready = 1'b1;
      inj_v = 1'b0; inj_tid = 1'b0; inj_data = '0;

      // Reset state with both requesters asking
      tick(); tick();
      @(negedge clk);
      chk_val("rst_e_tvalid", e_tvalid, 1'b0);
      chk_val("rst_s_tready", {s1_tready, s0_tready}, 2'b00);
      chk_val("rst_m_tvalid", {m1_tvalid, m0_tvalid}, 2'b00);
      chk_val("rst_r_tready", r_tready, 1'b1);
      chk_val("rst_err_ovf", err_ovf, 1'b0);
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      tick();
      rst = 1'b0;

      // Single requester: 2,3,4 -> 32,243,1024
      m0_tready = 1'b0; m1_tready = 1'b0;
      s0_tvalid = 1'b1; s0_tdata = 2;
      @(negedge clk);
      chk_val("t1_s0_tready", s0_tready, 1'b1);
      chk_val("t1_e_tid", e_tid, 1'b0);
      chk_val("t1_e_tdata", e_tdata, 2);
      tick();
      s0_tdata = 3;
      @(negedge clk);
      chk_val("t1_e_tdata", e_tdata, 3);
      tick();
      s0_tdata = 4;
      @(negedge clk);
      chk_val("t1_e_tdata", e_tdata, 4);
      tick();
      s0_tvalid = 1'b0; m0_tready = 1'b1;
      exp_q = '{32, 243, 1024};
      collect_m0("t1", 20, 1'b1);

      // Contention: alternating grants starting at requester 0
      do_reset();
      m0_tready = 1'b1; m1_tready = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 5; s1_tvalid = 1'b1; s1_tdata = 6;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         chk_val("t2_e_tid", e_tid, i[0]);
         chk_val("t2_s_tready", {s1_tready, s0_tready}, i[0] ? 2'b10 : 2'b01);
         tick();
      end
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      repeat (15) tick();

      // Credit limit: m0 blocked, requester 0 stops after FIFO_DEPTH issues
      m0_tready = 1'b0; m1_tready = 1'b1;
      s0_tvalid = 1'b1; s0_tdata = 2; s1_tvalid = 1'b1; s1_tdata = 3;
      n0 = 0; n1 = 0; n1_after = 0;
      for (int c = 0; c < 30; c++) begin
         @(negedge clk);
         if (s0_tready) n0++;
         if (s1_tready) begin
            n1++;
            if (n0 == 4) n1_after++;
         end
         tick();
      end
      chk_val("t3_s0_issues", n0, 4);
      chk_val("t3_s1_after_limit", n1_after > 0, 1'b1);
      @(negedge clk);
      chk_val("t3_s0_blocked", s0_tready, 1'b0);
      chk_val("t3_m0_held", m0_tvalid, 1'b1);
      tick();
      s0_tvalid = 1'b0; s1_tvalid = 1'b0; m0_tready = 1'b1;
      repeat (15) tick();

      // Engine stall: grant, data and pointer hold
      do_reset();
      s0_tvalid = 1'b1; s0_tdata = 7; s1_tvalid = 1'b1; s1_tdata = 9;
      e_tready = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         chk_val("t4_e_tvalid", e_tvalid, 1'b1);
         chk_val("t4_e_tid", e_tid, 1'b0);
         chk_val("t4_e_tdata", e_tdata, 7);
         chk_val("t4_s_tready", {s1_tready, s0_tready}, 2'b00);
         tick();
      end
      e_tready = 1'b1;
      @(negedge clk);
      chk_val("t4_release_tid0", e_tid, 1'b0);
      chk_val("t4_release_s0", s0_tready, 1'b1);
      tick();
      @(negedge clk);
      chk_val("t4_release_tid1", e_tid, 1'b1);
      tick();
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      repeat (15) tick();

      // Full buffer: simultaneous push/pop is legal, a lone push overflows
      do_reset();
      m0_tready = 1'b0;
      send0(1); send0(2); send0(3); send0(4);
      s0_tvalid = 1'b0;
      repeat (12) tick();
      @(negedge clk);
      chk_val("t5_full_head", m0_tdata, 1);
      chk_val("t5_ovf_pre", err_ovf, 1'b0);
      tick();
      m0_tready = 1'b1; inj_v = 1'b1; inj_tid = 1'b0; inj_data = 32'hAA;
      tick();
      m0_tready = 1'b0; inj_data = 32'hBB;
      @(negedge clk);
      chk_val("t5_ovf_pushpop", err_ovf, 1'b0);
      tick();
      inj_v = 1'b0;
      @(negedge clk);
      chk_val("t5_ovf_set", err_ovf, 1'b1);
      tick();
      m0_tready = 1'b1;
      exp_q = '{32, 243, 1024, 32'hAA};
      collect_m0("t5", 8, 1'b0);
      chk_val("t5_ovf_sticky", err_ovf, 1'b1);

      // Reset with three results in flight
      do_reset();
      @(negedge clk);
      chk_val("t6_ovf_cleared", err_ovf, 1'b0);
      tick();
      m0_tready = 1'b0;
      send0(5); send0(6); send0(7);
      s1_tvalid = 1'b1;
      rst = 1'b1;
      @(negedge clk);
      chk_val("t6_rst_e_tvalid", e_tvalid, 1'b0);
      chk_val("t6_rst_s_tready", {s1_tready, s0_tready}, 2'b00);
      chk_val("t6_rst_r_tready", r_tready, 1'b1);
      tick();
      rst = 1'b0; s0_tvalid = 1'b0; s1_tvalid = 1'b0;
      @(negedge clk);
      chk_val("t6_cnt0", dut.cnt_0, 0);
      chk_val("t6_cnt1", dut.cnt_1, 0);
      any_v = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         if (m0_tvalid || m1_tvalid) any_v = 1'b1;
         tick();
      end
      chk_val("t6_no_results", any_v, 1'b0);
      s0_tvalid = 1'b1; s0_tdata = 3; s1_tvalid = 1'b1; s1_tdata = 4;
      @(negedge clk);
      chk_val("t6_first_gnt_valid", e_tvalid, 1'b1);
      chk_val("t6_first_gnt_tid", e_tid, 1'b0);
      tick();
      s0_tvalid = 1'b0; s1_tvalid = 1'b0;

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
